motor_arm_seq: RTL and testbench

//  Upstream sequencer for the four-ESC PWM stage. Owns arming, spin-up/spin-down and per-motor slew limiting.

---
 rtl/motor_arm_seq_if.sv | 30 +++
 rtl/motor_arm_seq.sv | 175 +++++++++++++++++
 tb/tb_motor_arm_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/motor_arm_seq_if.sv
// Interface bundling the flight-control commands and the ESC-side outputs of motor_arm_seq.
// The master drives the commands; the slave (the sequencer) drives the speeds and status.
interface motor_arm_seq_if #(
  parameter int unsigned DATA_W = 11
);
  logic              arm;
  logic              kill;
  logic              upd;
  logic [DATA_W-1:0] frnt_cmd;
  logic [DATA_W-1:0] bck_cmd;
  logic [DATA_W-1:0] lft_cmd;
  logic [DATA_W-1:0] rght_cmd;
  logic [DATA_W-1:0] frnt_spd;
  logic [DATA_W-1:0] bck_spd;
  logic [DATA_W-1:0] lft_spd;
  logic [DATA_W-1:0] rght_spd;
  logic              motors_off;
  logic              armed;
  logic              ramping;

  modport master (
    output arm, kill, upd, frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, motors_off, armed, ramping
  );

  modport slave (
    input  arm, kill, upd, frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    output frnt_spd, bck_spd, lft_spd, rght_spd, motors_off, armed, ramping
  );
endinterface

// File: rtl/motor_arm_seq.sv
// Arming / spin-up / spin-down sequencer for the four-ESC PWM stage with per-motor slew limiting.
// Motor index order everywhere: 0=front, 1=back, 2=left, 3=right.
module motor_arm_seq #(
  parameter int unsigned DATA_W     = 11,
  parameter int unsigned ARM_CYCLES = 2500000,
  parameter int unsigned SLEW_DIV   = 500,
  parameter logic [DATA_W-1:0] SLEW_STEP = 11'd16,
  parameter logic [DATA_W-1:0] IDLE_SPD  = 11'd64,
  parameter logic [DATA_W-1:0] MAX_SPD   = 11'd1536
) (
  input  logic               clk,
  input  logic               rst_n,
  motor_arm_seq_if.slave     bus
);

  localparam int unsigned ACNT_W = $clog2(ARM_CYCLES + 1);
  localparam int unsigned TCNT_W = $clog2(SLEW_DIV + 1);
  localparam logic signed [DATA_W:0] STEP_S = {1'b0, SLEW_STEP};

  typedef enum logic [1:0] {S_OFF, S_ARM_WAIT, S_RUN, S_SPIN_DOWN} state_t;

  function automatic logic [DATA_W-1:0] sat_cmd(input logic [DATA_W-1:0] c);
    return (c > MAX_SPD) ? MAX_SPD : c;
  endfunction

  function automatic logic [DATA_W-1:0] run_target(input logic [DATA_W-1:0] c);
    return (c < IDLE_SPD) ? IDLE_SPD : c;
  endfunction

  // Difference is one bit wider than the speeds, so it can never wrap.
  function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] cur,
                                             input logic [DATA_W-1:0] tgt);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)       return cur + SLEW_STEP;
    else if (diff < -STEP_S) return cur - SLEW_STEP;
    else                     return tgt;
  endfunction

  state_t                   state_q, state_d;
  logic [3:0][DATA_W-1:0]   spd_q, spd_d;
  logic [3:0][DATA_W-1:0]   cmd_q, cmd_d;
  logic [3:0][DATA_W-1:0]   cmd_in;
  logic [3:0][DATA_W-1:0]   tgt_cur, tgt_nxt;
  logic [ACNT_W-1:0]        arm_cnt_q, arm_cnt_d;
  logic [TCNT_W-1:0]        tick_cnt_q, tick_cnt_d;
  logic                     arm_prev_q;
  logic                     motors_off_q, motors_off_d;
  logic                     armed_q, armed_d;
  logic                     ramping_q, ramping_d;
  logic                     arm_rise;
  logic                     tick;

  assign cmd_in[0] = bus.frnt_cmd;
  assign cmd_in[1] = bus.bck_cmd;
  assign cmd_in[2] = bus.lft_cmd;
  assign cmd_in[3] = bus.rght_cmd;

  assign arm_rise = bus.arm & ~arm_prev_q;
  assign tick     = (tick_cnt_q == TCNT_W'(SLEW_DIV - 1));

  always_comb begin
    state_d      = state_q;
    spd_d        = spd_q;
    cmd_d        = cmd_q;
    arm_cnt_d    = arm_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    motors_off_d = motors_off_q;
    armed_d      = armed_q;
    tgt_cur      = '0;
    tgt_nxt      = '0;

    if (bus.upd) begin
      for (int i = 0; i < 4; i++) cmd_d[i] = sat_cmd(cmd_in[i]);
    end

    // A tick on the same edge as upd slews toward the previously latched command.
    for (int i = 0; i < 4; i++) begin
      tgt_cur[i] = (state_q == S_RUN) ? run_target(cmd_q[i]) : '0;
    end

    if (bus.kill) begin
      state_d      = S_OFF;
      spd_d        = '0;
      motors_off_d = 1'b1;
      armed_d      = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          spd_d        = '0;
          motors_off_d = 1'b1;
          armed_d      = 1'b0;
          if (arm_rise) begin
            state_d      = S_ARM_WAIT;
            arm_cnt_d    = '0;
            motors_off_d = 1'b0;
          end
        end
        S_ARM_WAIT: begin
          spd_d = '0;
          if (!bus.arm) begin
            state_d      = S_OFF;
            motors_off_d = 1'b1;
          end else if (arm_cnt_q == ACNT_W'(ARM_CYCLES - 1)) begin
            state_d    = S_RUN;
            tick_cnt_d = '0;
            armed_d    = 1'b1;
          end else begin
            arm_cnt_d = arm_cnt_q + ACNT_W'(1);
          end
        end
        S_RUN, S_SPIN_DOWN: begin
          tick_cnt_d = tick ? '0 : tick_cnt_q + TCNT_W'(1);
          if (tick) begin
            for (int i = 0; i < 4; i++) spd_d[i] = slew(spd_q[i], tgt_cur[i]);
          end
          if (state_q == S_RUN) begin
            if (!bus.arm) state_d = S_SPIN_DOWN;
          end else if (bus.arm) begin
            state_d = S_RUN;
          end else if (spd_q == '0) begin
            state_d      = S_OFF;
            motors_off_d = 1'b1;
            armed_d      = 1'b0;
          end
        end
        default: begin
          state_d      = S_OFF;
          spd_d        = '0;
          motors_off_d = 1'b1;
          armed_d      = 1'b0;
        end
      endcase
    end

    // ramping is registered against the next state's targets so it lines up with spd.
    for (int i = 0; i < 4; i++) begin
      tgt_nxt[i] = (state_d == S_RUN) ? run_target(cmd_d[i]) : '0;
    end
    ramping_d = ((state_d == S_RUN) || (state_d == S_SPIN_DOWN)) && (spd_d != tgt_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      spd_q        <= '0;
      cmd_q        <= '0;
      arm_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      arm_prev_q   <= 1'b0;
      motors_off_q <= 1'b1;
      armed_q      <= 1'b0;
      ramping_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      spd_q        <= spd_d;
      cmd_q        <= cmd_d;
      arm_cnt_q    <= arm_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      arm_prev_q   <= bus.arm;
      motors_off_q <= motors_off_d;
      armed_q      <= armed_d;
      ramping_q    <= ramping_d;
    end
  end

  assign bus.frnt_spd   = spd_q[0];
  assign bus.bck_spd    = spd_q[1];
  assign bus.lft_spd    = spd_q[2];
  assign bus.rght_spd   = spd_q[3];
  assign bus.motors_off = motors_off_q;
  assign bus.armed      = armed_q;
  assign bus.ramping    = ramping_q;

endmodule

// File: tb/tb_motor_arm_seq.sv
// Directed bench for motor_arm_seq with short arm window and slew divider.
// Ticks land every 4 clocks starting 4 clocks after RUN entry; edge numbers in step comments are relative.
module tb_motor_arm_seq;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  motor_arm_seq_if #(.DATA_W(11)) bus ();

  motor_arm_seq #(
    .DATA_W(11), .ARM_CYCLES(10), .SLEW_DIV(4),
    .SLEW_STEP(11'd16), .IDLE_SPD(11'd64), .MAX_SPD(11'd1536)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_spd(input string tag, input logic [10:0] f, input logic [10:0] b,
                         input logic [10:0] l, input logic [10:0] r);
    chk({tag, ".frnt"}, 32'(bus.frnt_spd), 32'(f));
    chk({tag, ".bck"},  32'(bus.bck_spd),  32'(b));
    chk({tag, ".lft"},  32'(bus.lft_spd),  32'(l));
    chk({tag, ".rght"}, 32'(bus.rght_spd), 32'(r));
  endtask

  task automatic set_cmds(input logic [10:0] f, input logic [10:0] b,
                          input logic [10:0] l, input logic [10:0] r);
    bus.frnt_cmd = f; bus.bck_cmd = b; bus.lft_cmd = l; bus.rght_cmd = r;
    bus.upd = 1'b1;
    step(1);
    bus.upd = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.arm = 1'b0; bus.kill = 1'b0; bus.upd = 1'b0;
    bus.frnt_cmd = '0; bus.bck_cmd = '0; bus.lft_cmd = '0; bus.rght_cmd = '0;

    step(2);
    chk_spd("rst_spd", 0, 0, 0, 0);
    chk("rst_motors_off", 32'(bus.motors_off), 1);
    chk("rst_armed", 32'(bus.armed), 0);
    chk("rst_ramping", 32'(bus.ramping), 0);
    rst_n = 1'b1;
    step(1);
    chk("off_idle_motors_off", 32'(bus.motors_off), 1);

    // Arm edge then drop arm during the wait: back to OFF.
    bus.arm = 1'b1;
    step(1);
    chk("abort_aw_motors_off", 32'(bus.motors_off), 0);
    bus.arm = 1'b0;
    step(1);
    chk("abort_off_motors_off", 32'(bus.motors_off), 1);

    // Full arm with zero commands.
    bus.arm = 1'b1;
    step(1);                                    // E1: ARM_WAIT
    chk("aw_motors_off", 32'(bus.motors_off), 0);
    chk_spd("aw_spd", 0, 0, 0, 0);
    step(9);                                    // E10: still waiting
    chk("aw_armed_late", 32'(bus.armed), 0);
    step(1);                                    // E11: RUN
    chk("run_armed", 32'(bus.armed), 1);
    chk("run_ramping", 32'(bus.ramping), 1);
    chk_spd("run_entry", 0, 0, 0, 0);
    step(3);
    chk_spd("pre_tick", 0, 0, 0, 0);
    step(1);                                    // E15: first tick
    chk_spd("spin16", 16, 16, 16, 16);
    step(4);
    chk_spd("spin32", 32, 32, 32, 32);
    step(4);
    chk_spd("spin48", 48, 48, 48, 48);
    step(4);
    chk_spd("spin64", 64, 64, 64, 64);
    chk("idle_ramping", 32'(bus.ramping), 0);
    step(4);                                    // E31: tick, holds at idle
    chk_spd("idle_hold", 64, 64, 64, 64);

    // Front command to 100.
    set_cmds(11'd100, 11'd0, 11'd0, 11'd0);     // E32
    chk("cmd100_ramping", 32'(bus.ramping), 1);
    chk_spd("cmd100_latch", 64, 64, 64, 64);
    step(3);
    chk_spd("frnt80", 80, 64, 64, 64);
    step(4);
    chk_spd("frnt96", 96, 64, 64, 64);
    step(4);                                    // E43
    chk_spd("frnt100", 100, 64, 64, 64);
    chk("frnt100_ramping", 32'(bus.ramping), 0);

    // Oversized command saturates at MAX_SPD.
    set_cmds(11'd2000, 11'd0, 11'd0, 11'd0);    // E44
    chk("sat_ramping", 32'(bus.ramping), 1);
    step(3);
    chk("sat_tick1", 32'(bus.frnt_spd), 116);
    step(352);
    chk("sat_tick89", 32'(bus.frnt_spd), 1524);
    step(4);
    chk("sat_final", 32'(bus.frnt_spd), 1536);
    chk("sat_ramping_done", 32'(bus.ramping), 0);
    step(4);
    chk("sat_hold", 32'(bus.frnt_spd), 1536);

    // Back down to 100 to set up spin-down.
    set_cmds(11'd100, 11'd0, 11'd0, 11'd0);     // E408
    step(3);
    chk("down_tick1", 32'(bus.frnt_spd), 1520);
    step(352);
    chk("down_tick89", 32'(bus.frnt_spd), 112);
    step(4);                                    // E767
    chk_spd("down_final", 100, 64, 64, 64);

    // Spin-down, then re-arm mid-ramp.
    bus.arm = 1'b0;
    step(1);
    chk("sd_armed", 32'(bus.armed), 1);
    chk("sd_motors_off", 32'(bus.motors_off), 0);
    chk("sd_ramping", 32'(bus.ramping), 1);
    step(3);
    chk_spd("sd_t1", 84, 48, 48, 48);
    step(4);
    chk_spd("sd_t2", 68, 32, 32, 32);
    bus.arm = 1'b1;
    step(1);
    chk("rearm_armed", 32'(bus.armed), 1);
    chk("rearm_motors_off", 32'(bus.motors_off), 0);
    step(3);
    chk_spd("rearm_t1", 84, 48, 48, 48);
    step(4);
    chk_spd("rearm_t2", 100, 64, 64, 64);
    chk("rearm_ramping", 32'(bus.ramping), 0);

    // Full spin-down to OFF.
    bus.arm = 1'b0;
    step(4);
    chk_spd("sd2_t1", 84, 48, 48, 48);
    step(12);
    chk_spd("sd2_t4", 36, 0, 0, 0);
    step(12);                                   // all four reach 0
    chk_spd("sd2_zero", 0, 0, 0, 0);
    chk("sd2_zero_motors_off", 32'(bus.motors_off), 0);
    chk("sd2_zero_armed", 32'(bus.armed), 1);
    chk("sd2_zero_ramping", 32'(bus.ramping), 0);
    step(1);
    chk("sd2_off_motors_off", 32'(bus.motors_off), 1);
    chk("sd2_off_armed", 32'(bus.armed), 0);

    // Kill during RUN with arm held.
    bus.arm = 1'b1;
    step(11);                                   // RUN entry
    chk("k_run_armed", 32'(bus.armed), 1);
    step(8);
    chk_spd("k_pre", 32, 32, 32, 32);
    bus.kill = 1'b1;
    step(1);
    chk_spd("k_spd", 0, 0, 0, 0);
    chk("k_motors_off", 32'(bus.motors_off), 1);
    chk("k_armed", 32'(bus.armed), 0);
    bus.kill = 1'b0;
    step(5);
    chk("k_held_motors_off", 32'(bus.motors_off), 1);
    bus.arm = 1'b0;
    step(1);
    chk("k_drop_motors_off", 32'(bus.motors_off), 1);
    bus.arm = 1'b1;
    step(1);
    chk("k_rearm_motors_off", 32'(bus.motors_off), 0);
    chk("k_rearm_armed", 32'(bus.armed), 0);

    // Ramp to 400 (commands latched during ARM_WAIT), then async reset.
    set_cmds(11'd400, 11'd400, 11'd400, 11'd400);
    step(9);
    chk("r_run_armed", 32'(bus.armed), 1);
    step(4);
    chk_spd("r_t1", 16, 16, 16, 16);
    step(96);
    chk_spd("r_400", 400, 400, 400, 400);
    chk("r_ramping", 32'(bus.ramping), 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_spd("async_rst", 0, 0, 0, 0);
    chk("async_rst_motors_off", 32'(bus.motors_off), 1);
    chk("async_rst_armed", 32'(bus.armed), 0);
    step(1);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
